// File: rtl/kgp_ctrl_pkg.sv
// Shared types and constants for the KGP-RISC multicycle control sequencer.
package kgp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  localparam logic [5:0] OP_ALU       = 6'h00;
  localparam logic [5:0] OP_ALUI_BASE = 6'h10;
  localparam logic [5:0] OP_LW        = 6'h20;
  localparam logic [5:0] OP_SW        = 6'h21;
  localparam logic [5:0] OP_BCOND     = 6'h30;
  localparam logic [5:0] OP_BR        = 6'h31;
  localparam logic [5:0] OP_HALT      = 6'h3F;

  localparam logic [3:0] ALU_ADD = 4'h0;

  // One-hot instruction class produced by the decoder.
  typedef struct packed {
    logic alu_rr;
    logic alu_imm;
    logic lw;
    logic sw;
    logic bcond;
    logic br;
    logic halt;
    logic illegal;
  } iclass_t;

endpackage

// File: rtl/kgp_ctrl_fsm_decode.sv
// Combinational opcode classifier for the KGP sequencer (module kgp_instr_decode).
// Optional feature macro: KGP_HALT_EN (opcode 6'h3F decodes as HALT instead of illegal).
module kgp_instr_decode
  import kgp_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [3:0] i_func,
  output iclass_t    o_class,
  output logic [3:0] o_alufunc
);

  always_comb begin
    o_class   = '0;
    o_alufunc = ALU_ADD;
    if (i_opcode == OP_ALU) begin
      o_class.alu_rr = 1'b1;
      o_alufunc      = i_func;
    end else if ((i_opcode & 6'h30) == OP_ALUI_BASE) begin
      o_class.alu_imm = 1'b1;
      o_alufunc       = i_opcode[3:0];
    end else if (i_opcode == OP_LW) begin
      o_class.lw = 1'b1;
    end else if (i_opcode == OP_SW) begin
      o_class.sw = 1'b1;
    end else if (i_opcode == OP_BCOND) begin
      o_class.bcond = 1'b1;
    end else if (i_opcode == OP_BR) begin
      o_class.br = 1'b1;
    end else if (i_opcode == OP_HALT) begin
`ifdef KGP_HALT_EN
      o_class.halt = 1'b1;
`else
      o_class.illegal = 1'b1;
`endif
    end else begin
      o_class.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/kgp_ctrl_fsm.sv
// KGP-RISC multicycle control FSM: sequences IF/ID/EX/MEM/WB and drives all datapath controls.
// Optional feature macro: KGP_HALT_EN (enables the HALT state for opcode 6'h3F).
module kgp_ctrl_fsm
  import kgp_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] irout,
  output logic        readim,
  output logic        ldir,
  output logic        ldnpc,
  output logic        ldA,
  output logic        ldB,
  output logic        ldimm,
  output logic        opcond,
  output logic        alusel1,
  output logic        alusel2,
  output logic        aluen,
  output logic        ldaluout,
  output logic [3:0]  alufunc,
  output logic        writedmem,
  output logic        readdmem,
  output logic        ldlmd,
  output logic        branch,
  output logic        ldpc,
  output logic        regwrite,
  output logic        selwb,
  output logic        instr_done,
  output logic        illegal,
  output logic        halted
);

  state_t     r_state;
  state_t     w_state_nxt;
  state_t     w_after;
  iclass_t    w_cls;
  logic [3:0] w_func;
  logic       r_illegal;
  logic       w_set_illegal;
  logic       w_unused;

  kgp_instr_decode u_dec (
    .i_opcode  (irout[31:26]),
    .i_func    (irout[3:0]),
    .o_class   (w_cls),
    .o_alufunc (w_func)
  );

  // Middle instruction bits belong to the datapath only.
  assign w_unused = ^irout[25:4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  assign w_after = run ? ST_IF : ST_IDLE;
  assign illegal = r_illegal;

`ifdef KGP_HALT_EN
  assign halted = (r_state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_set_illegal = 1'b0;
    readim     = 1'b0;  ldir     = 1'b0;  ldnpc    = 1'b0;
    ldA        = 1'b0;  ldB      = 1'b0;  ldimm    = 1'b0;
    opcond     = 1'b0;  alusel1  = 1'b0;  alusel2  = 1'b0;
    aluen      = 1'b0;  ldaluout = 1'b0;  alufunc  = '0;
    writedmem  = 1'b0;  readdmem = 1'b0;  ldlmd    = 1'b0;
    branch     = 1'b0;  ldpc     = 1'b0;
    regwrite   = 1'b0;  selwb    = 1'b0;  instr_done = 1'b0;
    case (r_state)
      ST_IDLE: if (run) w_state_nxt = ST_IF;
      ST_IF: begin
        readim = 1'b1; ldir = 1'b1; ldnpc = 1'b1;
        w_state_nxt = ST_ID;
      end
      ST_ID: begin
        ldA = 1'b1; ldB = 1'b1; ldimm = 1'b1;
        if (w_cls.halt) begin
          instr_done  = 1'b1;
          w_state_nxt = ST_HALT;
        end else if (w_cls.illegal) begin
          w_set_illegal = 1'b1;
          instr_done    = 1'b1;
          w_state_nxt   = w_after;
        end else begin
          w_state_nxt = ST_EX;
        end
      end
      ST_EX: begin
        aluen = 1'b1; ldaluout = 1'b1;
        alufunc = w_func;
        if (w_cls.alu_rr) begin
          alusel1 = 1'b1;
        end else if (w_cls.alu_imm || w_cls.lw || w_cls.sw) begin
          alusel1 = 1'b1; alusel2 = 1'b1;
        end else if (w_cls.bcond) begin
          alusel2 = 1'b1; opcond = 1'b1;
        end
        w_state_nxt = ST_MEM;
      end
      ST_MEM: begin
        ldpc      = 1'b1;
        readdmem  = w_cls.lw;
        ldlmd     = w_cls.lw;
        writedmem = w_cls.sw;
        branch    = w_cls.br;
        opcond    = w_cls.bcond;
        if (w_cls.alu_rr || w_cls.alu_imm || w_cls.lw) begin
          w_state_nxt = ST_WB;
        end else begin
          instr_done  = 1'b1;
          w_state_nxt = w_after;
        end
      end
      ST_WB: begin
        regwrite    = 1'b1;
        selwb       = w_cls.lw;
        instr_done  = 1'b1;
        w_state_nxt = w_after;
      end
      ST_HALT: begin
`ifdef KGP_HALT_EN
        w_state_nxt = ST_HALT;
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
